// File: rtl/k_alu_arbiter.sv
// ---------------------------------------------------------------------------
// k_alu_arbiter
//
// Two-port round-robin arbiter feeding a shared 32-bit ALU through a
// 2-stage pipeline (operand register S1 -> K_ALU_32 -> result register S2).
// Results return on one response channel tagged with the requester ID, and
// per-port completion counters track delivered responses.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   reqN_valid / reqN_ready    request handshake for port N (N = 0, 1)
//   reqN_a, reqN_b, reqN_sel   operands and ALU select for port N
//   resp_valid / resp_ready    response handshake (driven from S2)
//   resp_res, resp_id          ALU result and issuing port
//   done_cnt0, done_cnt1       responses delivered per port (wrapping)
//   busy                       any pipeline stage occupied
//
// Also contains K_ALU_32, the combinational 32-bit ALU:
//   a_i, b_i   operands
//   sel_i      operation select
//   res_o      result
// ---------------------------------------------------------------------------

module K_ALU_32 (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [3:0]  sel_i,
    output logic [31:0] res_o
);
    always_comb begin
        res_o = 32'd0;
        case (sel_i)
            4'd0:  res_o = a_i + b_i;
            4'd1:  res_o = a_i - b_i;
            4'd2:  res_o = a_i & b_i;
            4'd3:  res_o = a_i | b_i;
            4'd4:  res_o = a_i ^ b_i;
            4'd5:  res_o = ~(a_i | b_i);
            4'd6:  res_o = a_i << b_i[4:0];
            4'd7:  res_o = a_i >> b_i[4:0];
            4'd8:  res_o = $signed(a_i) >>> b_i[4:0];
            4'd9:  res_o = {31'd0, $signed(a_i) < $signed(b_i)};
            4'd10: res_o = {31'd0, a_i < b_i};
            4'd11: res_o = a_i * b_i;
            4'd12: res_o = b_i;
            4'd13: res_o = ~(a_i & b_i);
            4'd14: res_o = ~(a_i ^ b_i);
            default: res_o = 32'd0;
        endcase
    end
endmodule

module k_alu_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [3:0]       req0_sel,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [3:0]       req1_sel,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_res,
    output logic             resp_id,
    output logic [CNT_W-1:0] done_cnt0,
    output logic [CNT_W-1:0] done_cnt1,
    output logic             busy
);
    // Control state: one valid bit per stage plus the round-robin pointer.
    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic prio_q, prio_d;

    // Datapath registers.
    logic [31:0] s1_a_q, s1_b_q;
    logic [3:0]  s1_sel_q;
    logic        s1_id_q;
    logic [31:0] s2_res_q;
    logic        s2_id_q;
    logic [CNT_W-1:0] done_cnt_q [2];

    // Combinational control.
    logic        s2_adv, s1_free, consume;
    logic        grant0, grant1;
    logic        accept, acc_id;
    logic [31:0] acc_a, acc_b;
    logic [3:0]  acc_sel;
    logic [31:0] alu_res;

    K_ALU_32 u_alu (
        .a_i   (s1_a_q),
        .b_i   (s1_b_q),
        .sel_i (s1_sel_q),
        .res_o (alu_res)
    );

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            prio_q     <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            prio_q     <= prio_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        prio_d     = prio_q;
        // An accept refills S1 even when S1 drains into S2 on the same edge.
        if (accept)
            s1_valid_d = 1'b1;
        else if (s2_adv)
            s1_valid_d = 1'b0;
        // A new result replacing a consumed one keeps S2 full.
        if (s2_adv)
            s2_valid_d = 1'b1;
        else if (consume)
            s2_valid_d = 1'b0;
        // The port just served loses the next conflict.
        if (accept)
            prio_d = ~acc_id;
    end

    // ---------------- output / control logic ----------------
    always_comb begin
        consume = s2_valid_q & resp_ready;
        s2_adv  = s1_valid_q & (~s2_valid_q | resp_ready);
        s1_free = ~s1_valid_q | s2_adv;
        grant0  = req0_valid & (~req1_valid | ~prio_q);
        grant1  = req1_valid & (~req0_valid |  prio_q);
        req0_ready = grant0 & s1_free;
        req1_ready = grant1 & s1_free;
        accept  = (req0_valid & req0_ready) | (req1_valid & req1_ready);
        acc_id  = req1_valid & req1_ready;
        acc_a   = acc_id ? req1_a   : req0_a;
        acc_b   = acc_id ? req1_b   : req0_b;
        acc_sel = acc_id ? req1_sel : req0_sel;
        busy    = s1_valid_q | s2_valid_q;
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_a_q   <= 32'd0;
            s1_b_q   <= 32'd0;
            s1_sel_q <= 4'd0;
            s1_id_q  <= 1'b0;
        end else if (accept) begin
            s1_a_q   <= acc_a;
            s1_b_q   <= acc_b;
            s1_sel_q <= acc_sel;
            s1_id_q  <= acc_id;
        end
    end

    // S2 only loads on advance, so the response is held stable while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_res_q <= 32'd0;
            s2_id_q  <= 1'b0;
        end else if (s2_adv) begin
            s2_res_q <= alu_res;
            s2_id_q  <= s1_id_q;
        end
    end

    // Per-port completion counters, bumped on each delivered response.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            localparam logic PORT_ID = 1'(gi);
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    done_cnt_q[gi] <= '0;
                else if (consume && (s2_id_q == PORT_ID))
                    done_cnt_q[gi] <= done_cnt_q[gi] + CNT_W'(1);
            end
        end
    endgenerate

    assign resp_valid = s2_valid_q;
    assign resp_res   = s2_res_q;
    assign resp_id    = s2_id_q;
    assign done_cnt0  = done_cnt_q[0];
    assign done_cnt1  = done_cnt_q[1];

endmodule

// File: tb/tb_k_alu_arbiter.sv
module tb_k_alu_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_sel, req1_sel;
    logic        resp_valid, resp_ready, resp_id, busy;
    logic [31:0] resp_res;
    logic [3:0]  done_cnt0, done_cnt1;

    always #5 clk = ~clk;

    k_alu_arbiter #(.CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_sel   (req0_sel),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_sel   (req1_sel),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_res   (resp_res),
        .resp_id    (resp_id),
        .done_cnt0  (done_cnt0),
        .done_cnt1  (done_cnt1),
        .busy       (busy)
    );

    typedef struct packed {
        logic        id;
        logic [31:0] res;
    } exp_t;

    int   n_vec  = 0;
    int   n_fail = 0;
    exp_t sb[$];
    int   grant_log[$];
    time  acc_times[$];
    time  resp_times[$];
    exp_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Present one op on port p and hold it until accepted; the expected
    // response is queued at the accepting edge.
    task automatic drive(input int p, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] sel, input logic [31:0] exp, output int waits);
        bit   done;
        exp_t e;
        done  = 1'b0;
        waits = 0;
        if (p == 0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sel = sel;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sel = sel;
        end
        while (!done) begin
            @(negedge clk);
            if ((p == 0 && req0_ready) || (p == 1 && req1_ready)) begin
                @(posedge clk);
                e.id  = p[0];
                e.res = exp;
                sb.push_back(e);
                grant_log.push_back(p);
                acc_times.push_back($time);
                $display("req  port=%0d a=0x%08h b=0x%08h sel=%0d accepted t=%0t", p, a, b, sel, $time);
                #1;
                done = 1'b1;
            end else begin
                waits++;
                if (waits > 50) begin
                    n_fail++;
                    $display("FAIL accept_timeout: port %0d not accepted after %0d cycles, expected accept", p, waits);
                    done = 1'b1;
                end
            end
        end
        if (p == 0) req0_valid = 1'b0;
        else        req1_valid = 1'b0;
    endtask

    // Wait (bounded) until every queued response has been delivered.
    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d responses outstanding, expected 0", name, sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every delivered response is popped and compared.
    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready) begin
            resp_times.push_back($time);
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL resp_unexpected: got id=%0d res=0x%08h, expected no response", resp_id, resp_res);
            end else begin
                mon_e = sb.pop_front();
                check("resp_id", 32'(resp_id), 32'(mon_e.id));
                check("resp_res", resp_res, mon_e.res);
                $display("resp id=%0d res=0x%08h t=%0t", resp_id, resp_res, $time);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // Directed vectors: {a, b, sel, expected}
    logic [31:0] st_a   [8] = '{32'd5, 32'd5, 32'd3, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234, 32'hFF00};
    logic [31:0] st_b   [8] = '{32'd3, 32'd3, 32'd5, 32'd0, 32'd1, 32'd1, 32'h5678, 32'h0F0F};
    logic [3:0]  st_sel [8] = '{4'd0, 4'd1, 4'd1, 4'd5, 4'd9, 4'd10, 4'd12, 4'd14};
    logic [31:0] st_exp [8] = '{32'd8, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h5678, 32'hFFFF_0FF0};

    initial begin
        int  w, w0, w1, n;
        time t_last;
        int  exp_grant [6];
        exp_grant = '{0, 1, 0, 1, 0, 1};

        rst = 1'b1; resp_ready = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sel = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sel = '0;

        // ---- reset state ----
        #3;
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_res", resp_res, 32'd0);
        check("rst_resp_id", 32'(resp_id), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cnt0", 32'(done_cnt0), 32'd0);
        check("rst_cnt1", 32'(done_cnt1), 32'd0);
        req1_valid = 1'b1;
        #1;
        check("rst_ready1_follows", 32'(req1_ready), 32'd1);
        check("rst_ready0_idle", 32'(req0_ready), 32'd0);
        req1_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        // ---- single op ----
        resp_ready = 1'b1;
        drive(0, 32'd150, 32'd78, 4'd9, 32'd0, w);
        check("single_wait", 32'(w), 32'd0);
        @(negedge clk);
        check("single_lat_s1", 32'(resp_valid), 32'd0);
        @(negedge clk);
        check("single_lat_valid", 32'(resp_valid), 32'd1);
        check("single_lat_id", 32'(resp_id), 32'd0);
        drain("single");
        check("single_cnt0", 32'(done_cnt0), 32'd1);

        rst = 1'b1; sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;

        // ---- conflict fairness ----
        grant_log.delete();
        fork
            begin
                drive(0, 32'd10, 32'd20, 4'd0, 32'd30, w0);
                drive(0, 32'd100, 32'd1, 4'd1, 32'd99, w0);
                drive(0, 32'h0000_F0F0, 32'h0000_0FF0, 4'd2, 32'h0000_00F0, w0);
            end
            begin
                drive(1, 32'h0A, 32'h05, 4'd3, 32'h0F, w1);
                drive(1, 32'hFF, 32'h0F, 4'd4, 32'hF0, w1);
                drive(1, 32'd1, 32'd4, 4'd6, 32'd16, w1);
            end
        join
        drain("conflict");
        check("conflict_grants", 32'(grant_log.size()), 32'd6);
        for (int i = 0; i < 6 && i < grant_log.size(); i++)
            check("conflict_grant_order", 32'(grant_log[i]), 32'(exp_grant[i]));
        check("conflict_cnt0", 32'(done_cnt0), 32'd3);
        check("conflict_cnt1", 32'(done_cnt1), 32'd3);

        // ---- backpressure ----
        resp_ready = 1'b0;
        grant_log.delete();
        fork
            begin
                drive(1, 32'h8000_0000, 32'd4, 4'd8, 32'hF800_0000, w1);
                drive(1, 32'h100, 32'd4, 4'd7, 32'h10, w1);
                drive(1, 32'd7, 32'd6, 4'd11, 32'd42, w1);
            end
            begin
                n = 0;
                while (grant_log.size() < 2 && n < 30) begin
                    @(negedge clk);
                    n++;
                end
                check("bp_two_accepted", 32'(grant_log.size()), 32'd2);
                for (int i = 0; i < 3; i++) begin
                    check("bp_ready1_stalled", 32'(req1_ready), 32'd0);
                    check("bp_busy", 32'(busy), 32'd1);
                    check("bp_resp_valid", 32'(resp_valid), 32'd1);
                    check("bp_resp_res_stable", resp_res, 32'hF800_0000);
                    check("bp_resp_id_stable", 32'(resp_id), 32'd1);
                    if (i < 2) @(negedge clk);
                end
                @(posedge clk); #1;
                resp_ready = 1'b1;
            end
        join
        drain("bp");
        check("bp_cnt1", 32'(done_cnt1), 32'd6);

        // ---- streaming ----
        acc_times.delete();
        resp_times.delete();
        for (int i = 0; i < 8; i++) begin
            drive(0, st_a[i], st_b[i], st_sel[i], st_exp[i], w);
            check("stream_wait", 32'(w), 32'd0);
        end
        t_last = acc_times[acc_times.size()-1];
        #14;
        check("stream_busy_k1", 32'(busy), 32'd1);
        #10;
        check("stream_busy_k2", 32'(busy), 32'd0);
        drain("stream");
        for (int i = 1; i < acc_times.size(); i++)
            check("stream_acc_gap", 32'(acc_times[i] - acc_times[i-1]), 32'd10);
        check("stream_resp_count", 32'(resp_times.size()), 32'd8);
        for (int i = 1; i < resp_times.size(); i++)
            check("stream_resp_gap", 32'(resp_times[i] - resp_times[i-1]), 32'd10);
        if (resp_times.size() > 0)
            check("stream_last_resp", 32'(resp_times[resp_times.size()-1] - t_last), 32'd15);
        check("stream_cnt0", 32'(done_cnt0), 32'd11);

        // ---- reset mid-flight ----
        resp_ready = 1'b0;
        drive(0, 32'd1, 32'd1, 4'd0, 32'd2, w);
        drive(0, 32'd2, 32'd2, 4'd0, 32'd4, w);
        @(negedge clk);
        check("mid_busy_pre", 32'(busy), 32'd1);
        check("mid_resp_valid_pre", 32'(resp_valid), 32'd1);
        check("mid_resp_res_pre", resp_res, 32'd2);
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        check("mid_resp_valid", 32'(resp_valid), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_resp_res", resp_res, 32'd0);
        check("mid_cnt0", 32'(done_cnt0), 32'd0);
        check("mid_cnt1", 32'(done_cnt1), 32'd0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("mid_prio_ready0", 32'(req0_ready), 32'd1);
        check("mid_prio_ready1", 32'(req1_ready), 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        resp_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("mid_no_stale", 32'(resp_valid), 32'd0);
        @(posedge clk); #1;

        // ---- counter wrap (CNT_W = 4) ----
        for (int i = 0; i < 17; i++)
            drive(0, 32'(i), 32'd1, 4'd0, 32'(i + 1), w);
        drain("wrap");
        check("wrap_cnt0", 32'(done_cnt0), 32'd1);
        check("wrap_cnt1", 32'(done_cnt1), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/k_alu_arbiter.md
# k_alu_arbiter

Two-port round-robin arbiter and 2-stage pipeline wrapper around one shared `K_ALU_32` instance. Two independent requesters, for example an execute unit and a debug/self-test port, submit operand/select triples over valid/ready handshakes. Each accepted operation flows through an operand register, then the combinational `K_ALU_32`, then a result register. The result is returned on a single response channel, tagged with the requester ID.

## Interface
Parameters:
- `CNT_W`, default 16: width of the per-port completion counters.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req0_valid`  in  1  port 0 request valid.
- `req0_ready`  out  1  port 0 request accepted this cycle.
- `req0_a`  in  32  port 0 operand A.
- `req0_b`  in  32  port 0 operand B.
- `req0_sel`  in  4  port 0 ALU select.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_sel`: same widths and meanings as port 0, for port 1.
- `resp_valid`  out  1  result register holds a valid result.
- `resp_ready`  in  1  consumer accepts the result.
- `resp_res`  out  32  `K_ALU_32` output for the operation.
- `resp_id`  out  1  requester (0/1) that issued the operation.
- `done_cnt0`  out  `CNT_W`  count of responses delivered to port 0.
- `done_cnt1`  out  `CNT_W`  count of responses delivered to port 1.
- `busy`  out  1  OR of the stage-1 and stage-2 valid bits.

## Operation
- Stage 1 (S1) registers: `s1_valid`, `s1_a`, `s1_b`, `s1_sel`, `s1_id`.
- Stage 2 (S2) registers: `s2_valid`, `s2_res`, `s2_id`. `resp_*` outputs are driven directly from S2.
- `K_ALU_32` inputs come from `s1_a`, `s1_b`, `s1_sel`. `sel` is passed through unmodified; the arbiter never interprets it.
- Advance conditions:
  - `s2_adv = s1_valid & (~s2_valid | resp_ready)`.
  - `s1_free = ~s1_valid | s2_adv`.
- Arbitration is combinational, with priority pointer `prio` (reset 0):
  - Only one port valid: that port is granted.
  - Both ports valid: port `prio` is granted.
  - `reqN_ready = grantN & s1_free`. At most one ready is high per cycle.
- On accept (`reqN_valid & reqN_ready`):
  - Operands, `sel` and ID N are loaded into S1; `s1_valid` is set.
  - `prio` is set to `~N`. This is round-robin: the loser of a conflict wins the next conflict.
- On `s2_adv`:
  - `s2_res` is loaded with the ALU output; `s2_id` with `s1_id`; `s2_valid` is set.
  - `s1_valid` clears unless a new accept happens in the same cycle.
- On `resp_valid & resp_ready` with no `s2_adv` in the same cycle: `s2_valid` clears.
- On every `resp_valid & resp_ready`: `done_cnt[resp_id]` increments and wraps modulo 2^`CNT_W`.
- Control state per stage is EMPTY or FULL, encoded by the valid bit:
  - S1: EMPTY→FULL on accept. FULL→EMPTY on `s2_adv` without accept. FULL→FULL on accept together with `s2_adv`, or on stall.
  - S2: EMPTY→FULL on `s2_adv`. FULL→EMPTY on consume without `s2_adv`. FULL→FULL otherwise.
- Reset values: all valid bits 0, `prio` 0, counters 0, data registers 0.
- As a consequence of reset: `resp_valid=0`, `resp_res=0`, `resp_id=0`, `busy=0`, and both readies follow their port's valid.
- Reset asserted mid-operation discards all in-flight operations. No response is produced for them and counters are not incremented.

## Timing
- Latency: request accepted at edge k → `resp_valid` high after edge k+1, provided S2 is free.
- Throughput: 1 operation/cycle when `resp_ready` is held high.
- `reqN_ready` depends combinationally on both valids, `prio`, S1/S2 state and `resp_ready`.
  - No combinational path exists from any `reqN_ready` to a valid.
  - Requesters must not drop `valid` or change operands/`sel` while `valid & ~ready`.
- `resp_res` and `resp_id` are stable while `resp_valid & ~resp_ready`.
- Full pipeline (both stages FULL) with `resp_ready=0`: both readies are 0 and nothing is lost.
- Response ordering is strictly acceptance order. Responses are never reordered across ports.

## Test plan
- Single op: port 0 presents A=150, B=78, sel=9 for one cycle, `resp_ready=1` → `req0_ready=1` at cycle 0; `resp_valid=1`, `resp_id=0` at cycle 2; `resp_res` equals a standalone `K_ALU_32` given the same inputs; `done_cnt0=1`.
- Conflict fairness: both ports valid continuously for 6 cycles, `resp_ready=1` → grants alternate 0,1,0,1,0,1; final `done_cnt0=3`, `done_cnt1=3`; `resp_id` sequence 0,1,0,1,0,1.
- Backpressure: `resp_ready=0`, port 1 streams 3 ops → first two accepted; third sees `req1_ready=0`. Then raise `resp_ready` → all 3 results delivered in order with stable data while stalled.
- Streaming: port 0 sends 8 back-to-back ops with `resp_ready=1` → one accept per cycle, 8 consecutive response cycles, `busy` drops 2 cycles after the last accept.
- Reset mid-flight: assert `rst` asynchronously with both stages FULL → `resp_valid`, `busy`, both counters and `prio` go to 0 immediately; no stale response appears after release.
- Counter wrap, run with `CNT_W=4`: 17 port-0 responses → `done_cnt0=1`.
